// File: rtl/tub_scan_pwm_pkg.sv
// tub_scan_pwm_pkg: shared widths, blank pattern and digit-select helper for the tube scanner
package tub_scan_pwm_pkg;
  localparam int SEG_W = 8;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;
  localparam int PWM_W = 4;
  // digit 0 is leftmost, so it maps to the most significant select bit
  function automatic logic [31:0] onehot_msb(input int idx, input int n);
    return 32'd1 << (n - 1 - idx);
  endfunction
endpackage

// File: rtl/tub_scan_pwm_if.sv
// tub_scan_pwm_if: display register inputs and tube pin outputs of the scanner
interface tub_scan_pwm_if import tub_scan_pwm_pkg::*; #(parameter int NUM_DIGITS = 8);
  logic                        scan_en;
  logic [SEG_W*NUM_DIGITS-1:0] digit_data;
  logic [NUM_DIGITS-1:0]       digit_en;
  logic [PWM_W-1:0]            brightness;
  logic [NUM_DIGITS-1:0]       tub_sel;
  logic [SEG_W-1:0]            tub_left;
  logic [SEG_W-1:0]            tub_right;
  logic                        scan_tick;
  modport master(output scan_en, digit_data, digit_en, brightness,
                 input tub_sel, tub_left, tub_right, scan_tick);
  modport slave(input scan_en, digit_data, digit_en, brightness,
                output tub_sel, tub_left, tub_right, scan_tick);
endinterface

// File: rtl/tub_scan_pwm_prescaler.sv
// tub_prescaler: enabled modulo-DIV counter with terminal-count pulse
module tub_prescaler #(
  parameter int DIV = 2,
  localparam int CW = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);
  assign tc = en && (count == CW'(DIV - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (en) count <= tc ? '0 : count + 1'b1;
endmodule

// File: rtl/tub_scan_pwm.sv
// tub_scan_pwm: multiplexed 7-segment scanner with slot blanking, digit enables and PWM dimming
module tub_scan_pwm import tub_scan_pwm_pkg::*; #(
  parameter int NUM_DIGITS      = 8,
  parameter int DIGITS_PER_BANK = 4,
  parameter int SCAN_DIV        = 100000,
  parameter int BLANK_CYCLES    = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  tub_scan_pwm_if.slave bus
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0]    div_cnt;
  logic             wrap;
  logic [IW-1:0]    idx;
  logic [PWM_W-1:0] pwm_cnt, snap_bri, cur_bri;
  logic [SEG_W-1:0] snap_pat, cur_pat;
  logic             snap_en, cur_en, slot_start, lit_win, lit, show, left_bank;
  tub_prescaler #(.DIV(SCAN_DIV)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (bus.scan_en),
    .count(div_cnt),
    .tc   (wrap)
  );
  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign lit_win = 1'b1;
    end else begin : g_blank
      assign lit_win = div_cnt >= CW'(BLANK_CYCLES);
    end
  endgenerate
  // on the slot's first cycle the snapshot is being loaded, so use the live inputs
  always_comb begin
    slot_start = div_cnt == '0;
    cur_pat    = slot_start ? bus.digit_data[SEG_W*int'(idx) +: SEG_W] : snap_pat;
    cur_en     = slot_start ? bus.digit_en[idx] : snap_en;
    cur_bri    = slot_start ? bus.brightness : snap_bri;
    lit        = {1'b0, pwm_cnt} < ({1'b0, cur_bri} + 5'd1);
    show       = bus.scan_en && lit_win && lit && cur_en;
    left_bank  = int'(idx) < DIGITS_PER_BANK;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx           <= '0;
      pwm_cnt       <= '0;
      snap_pat      <= SEG_BLANK;
      snap_en       <= 1'b0;
      snap_bri      <= '0;
      bus.tub_sel   <= '0;
      bus.tub_left  <= SEG_BLANK;
      bus.tub_right <= SEG_BLANK;
      bus.scan_tick <= 1'b0;
    end else begin
      if (wrap) idx <= (int'(idx) == NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      if (bus.scan_en) pwm_cnt <= pwm_cnt + 1'b1;
      if (bus.scan_en && slot_start) begin
        snap_pat <= cur_pat;
        snap_en  <= cur_en;
        snap_bri <= cur_bri;
      end
      bus.tub_sel   <= show ? NUM_DIGITS'(onehot_msb(int'(idx), NUM_DIGITS)) : '0;
      bus.tub_left  <= (show && left_bank) ? cur_pat : SEG_BLANK;
      bus.tub_right <= (show && !left_bank) ? cur_pat : SEG_BLANK;
      bus.scan_tick <= bus.scan_en && slot_start;
    end
endmodule
